// File: rtl/cpu16_pkg.sv
// Shared definitions for the cpu16 core slice: data width, default data
// memory depth and the load/store unit state encoding.
package cpu16_pkg;

  // Width of a data word moved between the core and the data memory.
  localparam int DATA_W = 16;

  // Number of valid word addresses in the default data memory.
  localparam int MEM_DEPTH_DEFAULT = 64;

  // Load/store unit sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller. Accepts one request at a time, drives a
// single-cycle read or write strobe to the data memory, and presents the
// result on a response port until the consumer takes it.
//
// Optional feature: define LSU_RANGE_CHECK_EN to reject addresses at or above
// MEM_DEPTH. A rejected request skips the memory access entirely and returns
// rsp_err=1 with rsp_rdata=0. Without the macro rsp_err is always 0 and every
// address reaches the memory unchanged.
//
// Handshakes: both ports use valid/ready. A transfer happens on the posedge
// where valid && ready are both 1. The requester holds req_* stable while
// req_valid is 1 and req_ready is 0; the block holds rsp_* stable while
// rsp_valid is 1 and rsp_ready is 0.
//
// The memory registers mem_rdata on the negedge inside the ISSUE cycle, so
// the read data is already valid at the posedge that ends ISSUE.
module lsu_mem_ctrl
  import cpu16_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int TAG_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  // request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [7:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  // data memory port
  output logic              mem_we,
  output logic              mem_re,
  output logic [7:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // current FSM state for observation
  output logic [1:0]        state_dbg
);

  // A depth beyond the 8-bit address space cannot be represented.
  if (MEM_DEPTH < 1 || MEM_DEPTH > 256) begin : g_depth_check
    $error("lsu_mem_ctrl: MEM_DEPTH must be in 1..256");
  end

  lsu_state_t          state;
  logic                lat_store;
  logic [TAG_W-1:0]    lat_tag;
  logic                out_of_range;

  assign state_dbg = state;

  // Decide whether the presented request address must be rejected.
  always_comb begin
    out_of_range = 1'b0;
`ifdef LSU_RANGE_CHECK_EN
    out_of_range = (int'({24'd0, req_addr}) >= MEM_DEPTH);
`endif
  end

  // Request sequencing: IDLE accepts, ISSUE strobes memory, RESP holds result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_store <= 1'b0;
      lat_tag   <= '0;
    end else begin
      // strobes are single-cycle pulses unless the IDLE branch raises one
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            lat_store <= req_is_store;
            lat_tag   <= req_tag;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            if (out_of_range) begin
              // rejected: no memory access, respond immediately
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_tag   <= req_tag;
              state     <= ST_RESP;
            end else begin
              mem_we    <= req_is_store;
              mem_re    <= ~req_is_store;
              rsp_err   <= 1'b0;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // memory has registered read data on the preceding negedge
          rsp_rdata <= lat_store ? '0 : mem_rdata;
          rsp_tag   <= lat_tag;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
